// File: rtl/rr_arbiter8_encoded.sv
// Round-robin arbiter for 8 requesters with one-hot and encoded grant.
// Each grant is capped at MAX_HOLD cycles and is followed by one idle cycle.
module rr_arbiter8_encoded #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N-1:0]     req,
  input  logic             owner_done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             gnt_timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]   hold_cnt, cnt_n;
  logic [N-1:0]       gnt_n;
  logic [IDX_W-1:0]   idx_n;
  logic               valid_n;
  logic               to_n;

  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   k;
  logic               found;
  logic               at_max;
  logic               keep;
  logic               end_c;

  // Rotating priority search starting at ptr.
  always_comb begin
    win   = '0;
    k     = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = ptr + IDX_W'(i);
      if (!found && req[k]) begin
        win   = k;
        found = 1'b1;
      end
    end
  end

  assign at_max = (hold_cnt == CNT_W'(MAX_HOLD));
  assign keep   = enable && req[gnt_idx] && !owner_done;
  assign end_c  = !keep || at_max;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = hold_cnt;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    valid_n = gnt_valid;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_n   = '0;
        idx_n   = '0;
        valid_n = 1'b0;
        if (enable && found) begin
          state_n = GRANT;
          gnt_n   = N'(1) << win;
          idx_n   = win;
          valid_n = 1'b1;
          cnt_n   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (end_c) begin
          state_n = IDLE;
          gnt_n   = '0;
          idx_n   = '0;
          valid_n = 1'b0;
          ptr_n   = gnt_idx + IDX_W'(1);
          cnt_n   = '0;
          // Timeout only when the hold limit alone ended the grant.
          to_n    = at_max && keep;
        end else if (!at_max) begin
          cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      gnt         <= '0;
      gnt_idx     <= '0;
      gnt_valid   <= 1'b0;
      gnt_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      hold_cnt    <= cnt_n;
      gnt         <= gnt_n;
      gnt_idx     <= idx_n;
      gnt_valid   <= valid_n;
      gnt_timeout <= to_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8_encoded.sv
// Directed bench for rr_arbiter8_encoded.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rr_arbiter8_encoded;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] req = '0;
  logic       owner_done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       gnt_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arbiter8_encoded dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .owner_done  (owner_done),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .gnt_timeout (gnt_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_idx"}, 32'(gnt_idx), 32'h0);
    check({tag, "_vld"}, 32'(gnt_valid), 32'h0);
  endtask

  task automatic chk_gnt(input string tag, input int idx);
    check({tag, "_gnt"}, 32'(gnt), 32'h1 << idx);
    check({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
    check({tag, "_vld"}, 32'(gnt_valid), 32'h1);
  endtask

  int cnt;

  initial begin
    // 1: reset holds everything idle despite requests
    req    = 8'hFF;
    enable = 1'b1;
    repeat (3) begin
      step();
      chk_idle("rst");
      check("rst_to", 32'(gnt_timeout), 32'h0);
    end
    reset = 1'b0;
    step();
    chk_gnt("rst_first", 0);

    // 2: single requester, drop request ends grant
    do_reset();
    req = 8'h01;
    step();
    chk_gnt("single", 0);
    req = 8'h00;
    step();
    chk_idle("single_drop");
    check("single_to", 32'(gnt_timeout), 32'h0);

    // 3: all requesting, release on first grant cycle, rotation with wrap
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      step();
      chk_gnt($sformatf("rot%0d", i), i % 8);
      owner_done = 1'b1;
      step();
      owner_done = 1'b0;
      chk_idle($sformatf("rot%0d_gap", i));
      check($sformatf("rot%0d_to", i), 32'(gnt_timeout), 32'h0);
    end

    // 4: hold limit on a lone requester
    do_reset();
    req = 8'h08;
    step();
    chk_gnt("hold_start", 3);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!gnt_valid) break;
      if (gnt_timeout) check("hold_early_to", 32'(gnt_timeout), 32'h0);
      cnt++;
    end
    check("hold_len", 32'(cnt), 32'd15);
    chk_idle("hold_gap");
    check("hold_to", 32'(gnt_timeout), 32'h1);
    step();
    check("hold_to_clr", 32'(gnt_timeout), 32'h0);
    chk_gnt("hold_regrant", 3);

    // 5: enable drop ends grant, ptr advances past owner
    do_reset();
    req = 8'h24;
    step();
    chk_gnt("en_first", 2);
    enable = 1'b0;
    step();
    chk_idle("en_drop");
    check("en_to", 32'(gnt_timeout), 32'h0);
    step();
    chk_idle("en_off1");
    step();
    chk_idle("en_off2");
    enable = 1'b1;
    step();
    chk_gnt("en_back", 5);

    // 6: asynchronous reset mid-grant
    do_reset();
    req = 8'h40;
    step();
    chk_gnt("mid_grant", 6);
    reset = 1'b1;
    #1;
    chk_idle("mid_async");
    req = 8'hC0;
    step();
    chk_idle("mid_held");
    reset = 1'b0;
    step();
    chk_gnt("mid_after", 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
